// File: rtl/fp32_div_seq.sv
// fp32_div_seq: iterative IEEE-754 single-precision divider.
// Truncating, subnormal-aware, one restoring quotient bit per cycle.
`timescale 1ns/1ps
module fp32_div_seq #(
  parameter logic [31:0] NAN_VALUE = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_res
);

  localparam int QBITS = 25;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLASS = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [23:0]       ma_q, ma_d, mb_q, mb_d;
  logic signed [9:0] ea_q, ea_d, eb_q, eb_d;
  logic              sign_q, sign_d;
  logic [25:0]       rem_q, rem_d;
  logic [24:0]       quo_q, quo_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       res_q, res_d;

  logic [7:0] xa, xb;
  logic       a_zero, a_inf, a_nan;
  logic       b_zero, b_inf, b_nan;
  logic       sp_nan, sp_inf, sp_zero;

  assign xa     = a_q[30:23];
  assign xb     = b_q[30:23];
  assign a_zero = (xa == 8'h00) && (a_q[22:0] == 23'd0);
  assign b_zero = (xb == 8'h00) && (b_q[22:0] == 23'd0);
  assign a_inf  = (xa == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (xb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (xa == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (xb == 8'hFF) && (b_q[22:0] != 23'd0);

  assign sp_nan  = a_nan | b_nan | (a_zero & b_zero)
                 | (a_inf & b_inf);
  assign sp_inf  = a_inf | b_zero;
  assign sp_zero = a_zero | b_inf;

  logic [23:0]       ma_c, mb_c;
  logic signed [9:0] ea_c, eb_c;

  assign ma_c = {xa != 8'h00, a_q[22:0]};
  assign mb_c = {xb != 8'h00, b_q[22:0]};
  assign ea_c = (xa == 8'h00) ? 10'sd1 : $signed({2'b00, xa});
  assign eb_c = (xb == 8'h00) ? 10'sd1 : $signed({2'b00, xb});

  logic [23:0]       ma_n, mb_n;
  logic signed [9:0] ea_n, eb_n;

  assign ma_n = ma_q[23] ? ma_q : {ma_q[22:0], 1'b0};
  assign mb_n = mb_q[23] ? mb_q : {mb_q[22:0], 1'b0};
  assign ea_n = ma_q[23] ? ea_q : ea_q - 10'sd1;
  assign eb_n = mb_q[23] ? eb_q : eb_q - 10'sd1;

  logic [25:0] mb_ext, rsub;
  logic        ge;

  assign mb_ext = {2'b00, mb_q};
  assign ge     = rem_q >= mb_ext;
  assign rsub   = ge ? rem_q - mb_ext : rem_q;

  // Result packing: quotient lies in [0.5, 2), so at most one
  // renormalising shift; underflow denormalises by right shift.
  logic signed [9:0] e_pre, e_adj;
  logic [23:0]       sig_n, sig_sh;
  logic [9:0]        sh;
  logic [31:0]       post_res;

  always_comb begin
    e_pre    = ea_q - eb_q + 10'sd127;
    sig_n    = quo_q[24] ? quo_q[24:1] : quo_q[23:0];
    e_adj    = quo_q[24] ? e_pre : e_pre - 10'sd1;
    sh       = $unsigned(10'sd1 - e_adj);
    sig_sh   = sig_n >> sh[4:0];
    post_res = {sign_q, e_adj[7:0], sig_n[22:0]};
    if (e_adj >= 10'sd255) begin
      post_res = {sign_q, 8'hFF, 23'd0};
    end else if (e_adj <= 10'sd0) begin
      if (sh >= 10'd24) post_res = {sign_q, 31'd0};
      else post_res = {sign_q, 8'h00, sig_sh[22:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          state_d = S_CLASS;
        end
      end
      S_CLASS: begin
        sign_d = a_q[31] ^ b_q[31];
        ma_d   = ma_c;
        mb_d   = mb_c;
        ea_d   = ea_c;
        eb_d   = eb_c;
        rem_d  = {2'b00, ma_c};
        quo_d  = '0;
        cnt_d  = '0;
        if (sp_nan) begin
          res_d   = NAN_VALUE;
          state_d = S_DONE;
        end else if (sp_inf) begin
          res_d   = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
          state_d = S_DONE;
        end else if (sp_zero) begin
          res_d   = {a_q[31] ^ b_q[31], 31'd0};
          state_d = S_DONE;
        end else if (ma_c[23] && mb_c[23]) begin
          state_d = S_DIV;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        ma_d  = ma_n;
        mb_d  = mb_n;
        ea_d  = ea_n;
        eb_d  = eb_n;
        rem_d = {2'b00, ma_n};
        if (ma_n[23] && mb_n[23]) state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = rsub << 1;
        quo_d = {quo_q[23:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1)) state_d = S_POST;
      end
      S_POST: begin
        res_d   = post_res;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      ea_q    <= '0;
      eb_q    <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign o_busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done = (state_q == S_DONE);
  assign o_res  = res_q;

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Iterative IEEE-754 single-precision divider; the inverse of the team's combinational fp32 multiplier. Computes o_res = i_a / i_b.
- Uses a start/busy/done handshake and a restoring mantissa divider that produces one quotient bit per cycle.
- Follows the same numeric conventions as the multiplier:
  - truncation rounding (toward zero);
  - subnormal inputs supported;
  - canonical NaN encoding.
- Sits beside the multiplier in the FP datapath and is shared by the control unit.

Parameters:
- NAN_VALUE, 32'hFFFF_FFFF, encoding driven for every invalid/NaN result.
- QBITS, 25, quotient bits produced by DIV (1 integer + 24 fraction); fixed for fp32, not to be overridden.

Ports:
- i_clk    input   1   clock; all logic on the rising edge.
- i_rst_n  input   1   synchronous reset, active-low.
- i_start  input   1   request; sampled only while o_busy=0.
- i_a      input   32  dividend; captured on the accepting edge.
- i_b      input   32  divisor; captured on the accepting edge.
- o_busy   output  1   operation in progress.
- o_done   output  1   one-cycle pulse; o_res is valid in this cycle.
- o_res    output  32  quotient; holds its value until the next o_done.

Behaviour:
- Reset (i_rst_n=0 at an edge) returns the FSM to IDLE and sets o_busy=0, o_done=0, o_res=0.
- Reset mid-operation aborts the operation silently: no o_done pulse is produced.
- FSM states:
  - IDLE: if i_start=1, capture i_a/i_b, set o_busy=1, go to CLASS. i_start is ignored while o_busy=1.
  - CLASS (1 cycle): classify each operand as zero / subnormal / normal / inf / NaN. Special results, in priority order:
    1. either operand NaN, 0/0, or inf/inf -> NAN_VALUE;
    2. inf/finite, or nonzero-finite/0 -> {Sa^Sb, 8'hFF, 23'b0};
    3. 0/nonzero, or finite/inf -> {Sa^Sb, 31'b0}.
    A special result loads o_res and goes to DONE. Otherwise go to NORM.
  - NORM: significands are 24 bits, with hidden bit = (exp!=0). Subnormals use effective exponent 1.
    - Each cycle, any significand with bit23=0 shifts left by 1 and its signed 10-bit exponent decrements by 1. Both operands may shift in the same cycle.
    - Exit to DIV when both have bit23=1; this takes 0 cycles for two normal operands.
  - DIV (QBITS cycles): R is initialised to Ma, 26 bits. Each step:
    - if R >= Mb: qbit=1 and R = R - Mb, else qbit=0;
    - then R = R << 1 and q = {q, qbit}.
  - POST (1 cycle): E = Ea - Eb + 127, signed 10-bit.
    - If q[24]=1: sig = q[24:1]. Else sig = q[23:0] and E = E - 1.
    - If E >= 255: result is inf with sign Sa^Sb.
    - If E <= 0: sig >>= (1 - E) and exp = 0. If the shift is >= 24, the result is signed zero.
    - Otherwise exp = E[7:0] and mantissa = sig[22:0]. Remainder bits are discarded (truncation).
    - Loads o_res and goes to DONE.
  - DONE: o_done=1 and o_busy=0 for exactly one cycle, then IDLE. An i_start in the DONE cycle is not accepted; the earliest accept is the following cycle.
- Result sign is always Sa^Sb except for NaN results.
- Latency, counted from the accepting edge to the o_done cycle:
  - special cases: 2 cycles;
  - normal/normal: 2 + 25 + 1 = 28 cycles;
  - plus 1 cycle per NORM cycle. Worst case is 23 extra cycles, when both operands are 0x00000001.
- o_res changes only on entry to DONE, or to 0 on reset.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> o_res=0x40400000, o_done exactly 28 cycles after accept; o_busy high throughout. Then 0x3F800000 / 0x40400000 (1.0/3.0) -> 0x3EAAAAAA (truncated).
- Specials, each done in 2 cycles:
  - 0x3F800000/0x00000000 -> 0x7F800000;
  - 0x80000000/0x00000000 -> 0xFFFFFFFF;
  - 0x7F800000/0xFF800000 -> 0xFFFFFFFF;
  - 0x7FC00000/0x3F800000 -> 0xFFFFFFFF;
  - 0x3F800000/0xFF800000 -> 0x80000000.
- Range limits:
  - overflow 0x7F000000/0x3F000000 -> 0x7F800000;
  - underflow to subnormal 0x00800000/0x40000000 -> 0x00400000;
  - flush to zero 0x00800000/0x7F000000 -> 0x00000000;
  - sign on negative divisor 0x40C00000/0xC0000000 -> 0xC0400000.
- Subnormal inputs: 0x00000001/0x00000001 -> 0x3F800000 with latency 28+23=51. 0x00400000/0x3F800000 -> 0x00400000.
- Handshake:
  - i_start held high continuously -> back-to-back operations with exactly one idle cycle between o_done and the next accept;
  - changes on i_a/i_b while busy do not affect the result.
- Reset: assert i_rst_n=0 mid-DIV -> the next cycle shows o_busy=0, o_done=0, o_res=0, and no o_done follows. A subsequent 6.0/2.0 completes normally with 0x40400000.
